data_mov_ctrl: RTL and testbench
================================

Name: data_mov_ctrl

Overview:
- Multi-cycle sequencer for the data-movement instructions LDW (5'b00001), STW (5'b00010) and MV (5'b00011).
- Sits between the decode stage and the register file / data-memory port. Takes one decoded instruction at a time over a valid/ready handshake.
- Drives register-file read/write strobes and a req/ack memory port, with a cycle timeout on memory.
- Signals completion or error back to decode.

Parameters:
- ADDR_W, 32, memory address width; the 16-bit imm is zero-extended to this width.
- DATA_W, 32, register/memory data width.
- REG_AW, 5, register index width.
- TIMEOUT, 16, max cycles in MEM waiting for mem_ack before abort (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decode presents an instruction
- instr_ready  out  1  controller can accept; high only in IDLE
- opcode  in  5  instruction opcode
- has_imm  in  1  MV source is imm rather than register rs
- imm  in  16  immediate / memory address
- rs  in  REG_AW  source register index
- rd  in  REG_AW  destination register index
- rf_raddr  out  REG_AW  register-file read index (combinational-read RF)
- rf_rdata  in  DATA_W  register-file read data
- rf_we  out  1  register-file write strobe, single cycle
- rf_waddr  out  REG_AW  write index
- rf_wdata  out  DATA_W  write data
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_addr  out  ADDR_W  zero-extended imm
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completes the request in this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- done  out  1  one-cycle pulse when an instruction retires
- err  out  1  one-cycle pulse on illegal opcode or timeout

Behaviour:
- **Reset:** async on rst_n low. State=IDLE. All outputs 0 except instr_ready=1. Internal latches and timeout counter cleared. Reset mid-transaction drops mem_req immediately, with no RF write.
- **Accept:** an instruction is accepted on a clk edge with instr_valid && instr_ready. opcode/has_imm/imm/rs/rd are latched; input values are ignored after acceptance.
- **States:** IDLE, RD, MEM, WB, FIN.
- **Transitions from IDLE on accept:**
  - MV with has_imm: go to WB.
  - MV without has_imm, or STW: go to RD.
  - LDW: go to MEM.
  - Any other opcode: stay in IDLE and pulse err the next cycle. No RF or memory activity.
- **RD:**
  - rf_raddr = latched rs.
  - rf_rdata is captured into a data register at the end of the cycle.
  - Then MV goes to WB; STW goes to MEM.
- **MEM:**
  - mem_req=1, mem_addr=zext(imm), mem_we=(STW), mem_wdata=captured data.
  - The timeout counter increments each MEM cycle without ack.
  - On mem_ack: LDW captures mem_rdata and goes to WB; STW goes to FIN.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, go to IDLE, pulse err. No done and no RF write.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
- **WB:** rf_we=1 for exactly one cycle, rf_waddr=latched rd, rf_wdata = zext(imm) (MV imm) or the captured data. Then go to FIN.
- **FIN:** done=1 for one cycle. Go to IDLE; instr_ready returns to 1 in the following cycle.
- **Latency** (accept edge = cycle 0; counts are cycles in which done is high):
  - MV imm: done in cycle 2.
  - MV reg: done in cycle 3.
  - STW: done at cycle 2+k, where k is the number of MEM cycles including the ack cycle (k>=1).
  - LDW: done at cycle 2+k.
- **Handshake rules:**
  - instr_ready=0 in every non-IDLE state.
  - mem_req never deasserts before ack except on timeout.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- **Ack outside MEM:** ignored.
- **Back-to-back:** the next instruction can be accepted in the cycle after FIN.

Decomposition:
- Shared package data_mov_pkg holds:
  - opcode localparams LDW/STW/MV;
  - read/write class codes REGS=2'b10, MEMORY=2'b01, NOTHING=2'b00;
  - the state encoding for IDLE/RD/MEM/WB/FIN.
- One natural sub-module, mem_timeout_ctr: clear and enable inputs, expired output, TIMEOUT parameter.

Test Plan:
1. MV imm=16'h00AB, rd=3 -> rf_we high exactly 1 cycle with rf_waddr=3, rf_wdata=32'h000000AB; done in cycle 2; no mem_req.
2. STW rs=5 (RF returns 32'hDEADBEEF), imm=16'h0100, ack after 3 cycles -> mem_req=1, mem_we=1, mem_addr=32'h100, mem_wdata=32'hDEADBEEF held stable for 3 cycles; done in cycle 5; rf_we never asserts.
3. LDW imm=16'h0040, rd=7, ack in the first MEM cycle with mem_rdata=32'h12345678 -> rf_we with waddr=7, wdata=32'h12345678; done in cycle 3.
4. LDW with no ack, TIMEOUT=16 -> mem_req drops after 16 MEM cycles; err pulses once; no done or rf_we; instr_ready returns high.
5. opcode=5'b00111 -> err pulse only; no rf_we or mem_req; next valid MV is accepted right away.
6. rst_n asserted low during MEM of a STW -> mem_req=0 and instr_ready=1 immediately (asynchronous); no done; an LDW issued after release completes normally.

Source files
------------

// File: rtl/data_mov_pkg.sv
// Shared definitions for the data-movement sequencer: opcodes, operand classes, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package data_mov_pkg;

  localparam logic [4:0] LDW = 5'b00001;
  localparam logic [4:0] STW = 5'b00010;
  localparam logic [4:0] MV  = 5'b00011;

  // Where an instruction's operand comes from / its result goes to
  localparam logic [1:0] REGS    = 2'b10;
  localparam logic [1:0] MEMORY  = 2'b01;
  localparam logic [1:0] NOTHING = 2'b00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    FIN  = 3'd4
  } state_e;

  function automatic logic is_legal(input logic [4:0] op);
    return (op == LDW) || (op == STW) || (op == MV);
  endfunction

  // Source class: MV-imm needs no fetch, LDW reads memory, MV-reg/STW read the RF
  function automatic logic [1:0] src_class(input logic [4:0] op, input logic has_imm);
    logic [1:0] c;
    c = NOTHING;
    if (op == LDW)               c = MEMORY;
    else if (op == STW)          c = REGS;
    else if (op == MV && !has_imm) c = REGS;
    return c;
  endfunction

  // Destination class: LDW/MV write the RF, STW writes memory
  function automatic logic [1:0] dst_class(input logic [4:0] op);
    logic [1:0] c;
    c = NOTHING;
    if (op == LDW || op == MV) c = REGS;
    else if (op == STW)        c = MEMORY;
    return c;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive un-acked memory cycles and flags the cycle that reaches TIMEOUT.
// Latency: expired_o is combinational on en_i in the TIMEOUT-th counted cycle.
// Backpressure: none; clr_i has priority over en_i.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The increment happening this cycle is the one that would reach TIMEOUT
  assign expired_o = en_i && (cnt_q == LAST);

  // Next count: cleared outside the wait, advanced on each waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/data_mov_ctrl.sv
// Sequencer for LDW/STW/MV: RF read, memory req/ack with timeout, RF writeback, done/err to decode.
// Latency: MV imm 2, MV reg 3, LDW/STW 2+k cycles after accept (k = MEM cycles incl. ack).
// Backpressure: instr_ready only in IDLE; mem_req held with stable addr/data until ack or timeout.
module data_mov_ctrl
  import data_mov_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        opcode,
  input  logic              has_imm,
  input  logic [15:0]       imm,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err
);

  state_e state_q, state_d;

  logic [4:0]        op_q;
  logic              has_imm_q;
  logic [15:0]       imm_q;
  logic [REG_AW-1:0] rs_q, rd_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q, err_d;
  logic              accept;
  logic              ctr_en, ctr_clr, expired;

  // Count only cycles spent waiting in MEM; any other state rearms the counter
  assign ctr_en  = (state_q == MEM) && !mem_ack;
  assign ctr_clr = (state_q != MEM);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (ctr_clr),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  // Next state and per-state strobes; ack in the expiring cycle still succeeds
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    mem_req     = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept = 1'b1;
          if (!is_legal(opcode)) begin
            err_d = 1'b1;
          end else begin
            case (src_class(opcode, has_imm))
              REGS:    state_d = RD;
              MEMORY:  state_d = MEM;
              default: state_d = WB;
            endcase
          end
        end
      end
      RD: begin
        state_d = (dst_class(op_q) == REGS) ? WB : MEM;
      end
      MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = (dst_class(op_q) == REGS) ? WB : FIN;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Instruction fields are captured at acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      has_imm_q <= 1'b0;
      imm_q     <= '0;
      rs_q      <= '0;
      rd_q      <= '0;
    end else if (accept) begin
      op_q      <= opcode;
      has_imm_q <= has_imm;
      imm_q     <= imm;
      rs_q      <= rs;
      rd_q      <= rd;
    end
  end

  // Data register: RF operand in RD, load data on the acking MEM cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state_q == RD) begin
      data_q <= rf_rdata;
    end else if (state_q == MEM && mem_ack && dst_class(op_q) == REGS) begin
      data_q <= mem_rdata;
    end
  end

  assign rf_raddr  = rs_q;
  assign rf_waddr  = rd_q;
  assign rf_wdata  = (op_q == MV && has_imm_q) ? DATA_W'(imm_q) : data_q;
  assign mem_we    = mem_req && (op_q == STW);
  assign mem_addr  = ADDR_W'(imm_q);
  assign mem_wdata = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mov_ctrl.sv
// Self-checking bench for data_mov_ctrl: directed table, async-reset sequence, random vs model.
// Latency: n/a.
// Backpressure: bench waits (bounded) on instr_ready before each issue.
module tb_data_mov_ctrl;

  localparam int TIMEOUT = 16;
  localparam logic [4:0] OP_LDW = 5'b00001;
  localparam logic [4:0] OP_STW = 5'b00010;
  localparam logic [4:0] OP_MV  = 5'b00011;

  typedef struct packed {
    logic [4:0]  op;
    logic        hi;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rd;
    logic [7:0]  k;      // MEM cycle carrying the ack (0 = never)
    logic [31:0] ld;     // load data returned with the ack
  } instr_t;

  typedef struct packed {
    logic [7:0]  done_cyc;
    logic [7:0]  err_cyc;
    logic [7:0]  we_cnt;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  req_cnt;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
  } exp_t;

  typedef struct packed {
    exp_t       r;
    logic       unstable;
    logic [7:0] ready_wait;
    logic       stray;
    logic       hang;
  } obs_t;

  typedef struct packed {
    instr_t in;
    exp_t   e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  opcode = '0;
  logic        has_imm = 1'b0;
  logic [15:0] imm = '0;
  logic [4:0]  rs = '0, rd = '0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        done, err;

  logic [31:0] rf_arr [32];
  int vectors = 0;
  int miscompares = 0;
  bit spur = 1'b0;

  always #5 clk = ~clk;

  assign rf_rdata = rf_arr[rf_raddr];

  data_mov_ctrl #(
    .ADDR_W(32), .DATA_W(32), .REG_AW(5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .has_imm(has_imm), .imm(imm), .rs(rs), .rd(rd),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic [4:0] op, input logic hi, input logic [15:0] im,
                                 input logic [4:0] s, input logic [4:0] d, input int k,
                                 input logic [31:0] ld, input int dc, input int ec, input int wc,
                                 input logic [4:0] wa, input logic [31:0] wd, input int rq,
                                 input logic rwe, input logic [31:0] ra, input logic [31:0] rwd);
    vec_t v;
    v.in = '{op: op, hi: hi, imm: im, rs: s, rd: d, k: 8'(k), ld: ld};
    v.e  = '{done_cyc: 8'(dc), err_cyc: 8'(ec), we_cnt: 8'(wc), waddr: wa, wdata: wd,
             req_cnt: 8'(rq), req_we: rwe, req_addr: ra, req_wdata: rwd};
    return v;
  endfunction

  // Reference: an instruction spends one cycle per phase it needs
  // (register fetch, each memory cycle, writeback) and retires one cycle later.
  function automatic exp_t model(input instr_t in);
    exp_t e;
    bit   acked;
    int   fetch, memc, wb;
    e = '0;
    acked = (in.k >= 1) && (int'(in.k) <= TIMEOUT);
    fetch = 0; memc = 0; wb = 0;
    if (in.op == OP_MV) begin
      fetch = in.hi ? 0 : 1;
      wb = 1;
      e.wdata = in.hi ? {16'h0, in.imm} : rf_arr[in.rs];
    end else if (in.op == OP_LDW || in.op == OP_STW) begin
      fetch = (in.op == OP_STW) ? 1 : 0;
      memc  = acked ? int'(in.k) : TIMEOUT;
      wb    = (in.op == OP_LDW) ? 1 : 0;
      e.wdata     = in.ld;
      e.req_cnt   = 8'(memc);
      e.req_we    = (in.op == OP_STW);
      e.req_addr  = {16'h0, in.imm};
      e.req_wdata = rf_arr[in.rs];
    end
    if (!(in.op == OP_MV || in.op == OP_LDW || in.op == OP_STW)) begin
      e.err_cyc = 8'd1;
    end else if (memc > 0 && !acked) begin
      e.err_cyc = 8'(fetch + memc + 1);
    end else begin
      e.done_cyc = 8'(fetch + memc + wb + 1);
      e.we_cnt   = 8'(wb);
      e.waddr    = wb ? in.rd : 5'd0;
    end
    return e;
  endfunction

  // Issue one instruction and watch the DUT until done/err (bounded).
  task automatic run_instr(input instr_t in, output obs_t o);
    int mc;
    int term;
    o = '0;
    mc = 0;
    term = 0;
    @(posedge clk); #1;
    while (!instr_ready && o.ready_wait < 8'd50) begin
      o.ready_wait++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b1;
    opcode = in.op; has_imm = in.hi; imm = in.imm; rs = in.rs; rd = in.rd;
    mem_ack = spur && ($urandom_range(0, 1) == 1);
    mem_rdata = $urandom;
    @(negedge clk);
    if (done || err || rf_we || mem_req) o.stray = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode = 5'($urandom); has_imm = 1'($urandom); imm = 16'($urandom);
    rs = 5'($urandom); rd = 5'($urandom);
    for (int c = 1; c <= 60; c++) begin
      if (mem_req && (mc + 1 == int'(in.k))) begin
        mem_ack = 1'b1;
        mem_rdata = in.ld;
      end else begin
        mem_ack = spur && !mem_req && ($urandom_range(0, 2) == 0);
        mem_rdata = $urandom;
      end
      @(negedge clk);
      if (mem_req) begin
        mc++;
        if (mc == 1) begin
          o.r.req_we = mem_we; o.r.req_addr = mem_addr; o.r.req_wdata = mem_wdata;
        end else if (mem_we !== o.r.req_we || mem_addr !== o.r.req_addr ||
                     mem_wdata !== o.r.req_wdata) begin
          o.unstable = 1'b1;
        end
      end
      if (rf_we) begin
        o.r.we_cnt++;
        o.r.waddr = rf_waddr;
        o.r.wdata = rf_wdata;
      end
      if (done && o.r.done_cyc == 8'd0) o.r.done_cyc = 8'(c);
      if (err && o.r.err_cyc == 8'd0) o.r.err_cyc = 8'(c);
      if (done || err) begin
        term = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    o.r.req_cnt = 8'(mc);
    if (term == 0) o.hang = 1'b1;
  endtask

  task automatic check_obs(input int idx, input exp_t e, input obs_t o);
    cmp("done_cycle", idx, 32'(o.r.done_cyc), 32'(e.done_cyc));
    cmp("err_cycle", idx, 32'(o.r.err_cyc), 32'(e.err_cyc));
    cmp("rf_we_count", idx, 32'(o.r.we_cnt), 32'(e.we_cnt));
    if (e.we_cnt != 0) begin
      cmp("rf_waddr", idx, 32'(o.r.waddr), 32'(e.waddr));
      cmp("rf_wdata", idx, o.r.wdata, e.wdata);
    end
    cmp("mem_req_cycles", idx, 32'(o.r.req_cnt), 32'(e.req_cnt));
    if (e.req_cnt != 0) begin
      cmp("mem_we", idx, 32'(o.r.req_we), 32'(e.req_we));
      cmp("mem_addr", idx, o.r.req_addr, e.req_addr);
      if (e.req_we) cmp("mem_wdata", idx, o.r.req_wdata, e.req_wdata);
      cmp("mem_stable", idx, 32'(o.unstable), 32'(0));
    end
    cmp("ready_wait", idx, 32'(o.ready_wait), 32'(0));
    cmp("stray_pulse", idx, 32'(o.stray), 32'(0));
    cmp("hang", idx, 32'(o.hang), 32'(0));
  endtask

  initial begin
    vec_t   tbl[$];
    obs_t   o;
    instr_t in;
    vec_t   v;
    int     sel, kr;

    for (int i = 0; i < 32; i++) rf_arr[i] = $urandom;
    rf_arr[5] = 32'hDEADBEEF;
    rf_arr[9] = 32'hCAFE0001;

    // Directed table: op hi imm rs rd k ld | done err we waddr wdata req req_we addr mwdata
    tbl.push_back(mkvec(OP_MV, 1, 16'h00AB, 0, 3, 0, 0,             2, 0, 1, 3, 32'h000000AB, 0, 0, 0, 0));
    tbl.push_back(mkvec(OP_STW, 0, 16'h0100, 5, 0, 3, 0,            5, 0, 0, 0, 0, 3, 1, 32'h100, 32'hDEADBEEF));
    tbl.push_back(mkvec(OP_LDW, 0, 16'h0040, 0, 7, 1, 32'h12345678, 3, 0, 1, 7, 32'h12345678, 1, 0, 32'h40, 0));
    tbl.push_back(mkvec(OP_LDW, 0, 16'h0200, 0, 2, 0, 32'h1,        0, 17, 0, 0, 0, 16, 0, 32'h200, 0));
    tbl.push_back(mkvec(5'b00111, 0, 16'h0055, 1, 1, 0, 0,          0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkvec(OP_MV, 1, 16'h00C1, 0, 4, 0, 0,             2, 0, 1, 4, 32'h000000C1, 0, 0, 0, 0));
    tbl.push_back(mkvec(OP_MV, 0, 16'h1234, 9, 1, 0, 0,             3, 0, 1, 1, 32'hCAFE0001, 0, 0, 0, 0));
    tbl.push_back(mkvec(OP_LDW, 0, 16'hFFFF, 0, 30, 16, 32'hA5A5A5A5, 18, 0, 1, 30, 32'hA5A5A5A5, 16, 0, 32'h0000FFFF, 0));
    tbl.push_back(mkvec(OP_STW, 0, 16'h0004, 5, 0, 0, 0,            0, 18, 0, 0, 0, 16, 1, 32'h4, 32'hDEADBEEF));
    tbl.push_back(mkvec(OP_STW, 1, 16'h0008, 9, 0, 1, 0,            3, 0, 0, 0, 0, 1, 1, 32'h8, 32'hCAFE0001));
    tbl.push_back(mkvec(OP_MV, 1, 16'h8000, 0, 31, 0, 0,            2, 0, 1, 31, 32'h00008000, 0, 0, 0, 0));
    tbl.push_back(mkvec(5'b00000, 1, 16'h0001, 2, 2, 0, 0,          0, 1, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    #1 rst_n = 1'b0;
    #20;
    cmp("rst_instr_ready", 0, 32'(instr_ready), 32'(1));
    cmp("rst_mem_req", 0, 32'(mem_req), 32'(0));
    cmp("rst_rf_we", 0, 32'(rf_we), 32'(0));
    cmp("rst_done", 0, 32'(done), 32'(0));
    cmp("rst_err", 0, 32'(err), 32'(0));
    cmp("rst_mem_addr", 0, mem_addr, 32'(0));
    cmp("rst_rf_wdata", 0, rf_wdata, 32'(0));
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].in, o);
      check_obs(i, tbl[i].e, o);
    end

    // Asynchronous reset while a STW waits in MEM
    @(posedge clk); #1;
    instr_valid = 1'b1; opcode = OP_STW; has_imm = 1'b0; imm = 16'h0300; rs = 5'd5; rd = 5'd0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("pre_rst_mem_req", 100, 32'(mem_req), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_mem_req", 100, 32'(mem_req), 32'(0));
    cmp("async_rst_ready", 100, 32'(instr_ready), 32'(1));
    cmp("async_rst_done", 100, 32'(done), 32'(0));
    cmp("async_rst_rf_we", 100, 32'(rf_we), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    v = mkvec(OP_LDW, 0, 16'h0010, 0, 12, 2, 32'h0BADF00D, 4, 0, 1, 12, 32'h0BADF00D, 2, 0, 32'h10, 0);
    run_instr(v.in, o);
    check_obs(101, v.e, o);

    // Randomized traffic with spurious acks outside MEM
    spur = 1'b1;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      kr  = $urandom_range(0, 9);
      in.op  = (sel == 0) ? (($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(4, 31)))
             : (sel <= 3) ? OP_MV : (sel <= 6) ? OP_LDW : OP_STW;
      in.hi  = 1'($urandom);
      in.imm = 16'($urandom);
      in.rs  = 5'($urandom);
      in.rd  = 5'($urandom);
      in.ld  = $urandom;
      in.k   = (kr == 0) ? 8'd0 : (kr == 1) ? 8'(TIMEOUT) : (kr == 2) ? 8'(TIMEOUT + 1)
             : 8'($urandom_range(1, 4));
      run_instr(in, o);
      check_obs(200 + n, model(in), o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
